// File: rtl/fractal_sync_cc_req.sv
// -----------------------------------------------------------------------------
// fractal_sync_cc_req
//   Core-side initiator of the fractal synchronization protocol. Takes one
//   barrier request (level, id) from the core, issues it as a check into the
//   first tree node, waits for the matching wake-up response and reports
//   either wake or error back to the core as a one-cycle pulse.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   sync_req_i/lvl/id    core barrier request (level-sensitive)
//   sync_gnt_o           request accepted (combinational in IDLE)
//   sync_wake_o          barrier complete pulse
//   sync_err_o           request failed pulse
//   sync_busy_o          FSM not IDLE
//   req_valid_o/lvl/id   tree request channel, req_ready_i handshake
//   rsp_valid_i/lvl/id   tree response channel, rsp_err_i tree error,
//   rsp_ready_o          response accepted (only in WAIT)
//
// Optional feature
//   FRACTAL_SYNC_CC_TIMEOUT_EN : WAIT gives up after TIMEOUT_CYCLES cycles
//   and reports an error. Without it WAIT is held until a response arrives.
// -----------------------------------------------------------------------------
module fractal_sync_cc_req #(
  parameter int unsigned LVL_WIDTH      = 3,
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned MAX_ID         = 2**ID_WIDTH-1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sync_req_i,
  input  logic [LVL_WIDTH-1:0] sync_lvl_i,
  input  logic [ID_WIDTH-1:0]  sync_id_i,
  output logic                 sync_gnt_o,
  output logic                 sync_wake_o,
  output logic                 sync_err_o,
  output logic                 sync_busy_o,
  output logic                 req_valid_o,
  output logic [LVL_WIDTH-1:0] req_lvl_o,
  output logic [ID_WIDTH-1:0]  req_id_o,
  input  logic                 req_ready_i,
  input  logic                 rsp_valid_i,
  input  logic [LVL_WIDTH-1:0] rsp_lvl_i,
  input  logic [ID_WIDTH-1:0]  rsp_id_i,
  input  logic                 rsp_err_i,
  output logic                 rsp_ready_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;

  state_e               r_state, w_state_nxt;
  logic [LVL_WIDTH-1:0] r_lvl;
  logic [ID_WIDTH-1:0]  r_id;
  logic                 r_err, w_err_nxt;
  logic                 w_load;
  logic                 w_bad_req;
  logic                 w_rsp_bad;
  logic                 w_timeout;

  // Illegal requests never reach the tree; they are answered locally.
  assign w_bad_req = (sync_lvl_i == '0) || (32'(sync_id_i) > MAX_ID);
  assign w_rsp_bad = rsp_err_i || (rsp_lvl_i != r_lvl) || (rsp_id_i != r_id);

`ifdef FRACTAL_SYNC_CC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES+1);
  logic [CNT_W-1:0] r_cnt;

  // Counter is zero on the first WAIT cycle, so the value TIMEOUT_CYCLES-1
  // marks the last WAIT cycle: the error pulse lands TIMEOUT_CYCLES cycles
  // after WAIT entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                r_cnt <= '0;
    else if (r_state != WAIT)   r_cnt <= '0;
    else                        r_cnt <= r_cnt + CNT_W'(1);
  end

  assign w_timeout = (r_state == WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES-1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_lvl   <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_load) begin
        r_lvl <= sync_lvl_i;
        r_id  <= sync_id_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    sync_gnt_o  = 1'b0;
    sync_wake_o = 1'b0;
    sync_err_o  = 1'b0;
    req_valid_o = 1'b0;
    rsp_ready_o = 1'b0;
    case (r_state)
      IDLE: begin
        sync_gnt_o = sync_req_i;
        if (sync_req_i) begin
          w_load      = 1'b1;
          w_err_nxt   = w_bad_req;
          w_state_nxt = w_bad_req ? RESP : SEND;
        end
      end
      SEND: begin
        req_valid_o = 1'b1;
        if (req_ready_i) w_state_nxt = WAIT;
      end
      WAIT: begin
        rsp_ready_o = 1'b1;
        // A response arriving on the expiry cycle still wins.
        if (rsp_valid_i) begin
          w_err_nxt   = w_rsp_bad;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        sync_wake_o = ~r_err;
        sync_err_o  = r_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign sync_busy_o = (r_state != IDLE);
  assign req_lvl_o   = r_lvl;
  assign req_id_o    = r_id;

endmodule
